// File: rtl/flow_stream_packer.sv
// flow_stream_packer: drops flow-core warm-up samples, tags SOF/EOL by pixel position, packs vx/vy into a FWFT FIFO on a valid/ready stream (ports: clk, rst_n, en, vx_in, vy_in, m_tdata/m_tvalid/m_tready/m_tuser/m_tlast, stall_req, overflow)
module flow_stream_packer #(
  parameter int FRAME_WIDTH = 1280,
  parameter int FRAME_HEIGHT = 720,
  parameter int RE_OF_OUT_WIDTH = 12,
  parameter int PIPE_LATENCY = 7700,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [RE_OF_OUT_WIDTH-1:0] vx_in,
  input  logic [RE_OF_OUT_WIDTH-1:0] vy_in,
  output logic [31:0]                m_tdata,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic                       m_tuser,
  output logic                       m_tlast,
  output logic                       stall_req,
  output logic                       overflow
);
  localparam int W = RE_OF_OUT_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int WCW = $clog2(PIPE_LATENCY + 1);
  localparam int XW = $clog2(FRAME_WIDTH + 1);
  localparam int YW = $clog2(FRAME_HEIGHT + 1);
  typedef enum logic {WARMUP, STREAM} state_t;
  state_t state, state_nx;
  logic [WCW-1:0] warm_cnt;
  logic [XW-1:0] col;
  logic [YW-1:0] row;
  logic [33:0] mem [FIFO_DEPTH];
  logic [33:0] word, head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nx;
  logic capture, pop, push, eol, eof;
  always_ff @(posedge clk)
    state <= !rst_n ? WARMUP : state_nx;
  always_comb
    state_nx = (state == WARMUP && en && warm_cnt == WCW'(PIPE_LATENCY - 1)) ? STREAM : state;
  always_comb
    capture = state == STREAM && en;
  always_comb begin
    eol = col == XW'(FRAME_WIDTH - 1);
    eof = row == YW'(FRAME_HEIGHT - 1);
    word = {col == '0 && row == '0, eol, {{(16 - W){vy_in[W-1]}}, vy_in}, {{(16 - W){vx_in[W-1]}}, vx_in}};
    pop = count != '0 && m_tready;
    push = capture && (count != CW'(FIFO_DEPTH) || pop);
    count_nx = count + CW'(push) - CW'(pop);
    head = mem[rd_ptr];
    m_tvalid = count != '0;
    m_tdata = m_tvalid ? head[31:0] : '0;
    m_tlast = m_tvalid ? head[32] : 1'b0;
    m_tuser = m_tvalid ? head[33] : 1'b0;
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= word;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      warm_cnt <= '0;
      col <= '0;
      row <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      stall_req <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (state == WARMUP && en) warm_cnt <= warm_cnt + 1'b1;
      if (capture) col <= eol ? '0 : col + 1'b1;
      if (capture && eol) row <= eof ? '0 : row + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nx;
      stall_req <= count_nx >= CW'(FIFO_DEPTH - 2);
      if (capture && !push) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_flow_stream_packer.sv
// tb_flow_stream_packer: queue-model self-checking bench for flow_stream_packer
module tb_flow_stream_packer;
  localparam int FW = 4, FH = 2, PL = 3, DEPTH = 4;
  logic clk = 0, rst_n = 0, en = 0, m_tready = 1;
  logic [11:0] vx_in = '0, vy_in = '0;
  logic [31:0] m_tdata;
  logic m_tvalid, m_tuser, m_tlast, stall_req, overflow;
  int tests = 0, fails = 0;
  logic [33:0] q[$];
  logic [33:0] log_q[$];
  int ecnt = 0;
  logic m_ovf = 0, m_stall = 0, started = 0;
  flow_stream_packer #(.FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .RE_OF_OUT_WIDTH(12),
    .PIPE_LATENCY(PL), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .vx_in(vx_in), .vy_in(vy_in),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tuser(m_tuser),
    .m_tlast(m_tlast), .stall_req(stall_req), .overflow(overflow));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [15:0] sx16(input logic [11:0] v);
    int t;
    t = $signed(v);
    return t[15:0];
  endfunction
  always @(posedge clk) begin
    automatic int n;
    automatic logic pop, acc;
    if (!rst_n) begin
      q.delete();
      ecnt = 0;
      m_ovf = 0;
      m_stall = 0;
      started = 1;
    end else begin
      pop = q.size() != 0 && m_tready;
      acc = 0;
      if (en && ecnt >= PL) begin
        n = ecnt - PL;
        acc = q.size() < DEPTH || pop;
        if (!acc) m_ovf = 1;
      end
      if (en) ecnt++;
      if (pop) void'(q.pop_front());
      if (acc) q.push_back({(n % FW == 0) && ((n / FW) % FH == 0), n % FW == FW - 1, sx16(vy_in), sx16(vx_in)});
      m_stall = q.size() >= DEPTH - 2;
    end
  end
  always @(negedge clk) if (started) begin
    chk("tvalid", m_tvalid, q.size() != 0);
    if (q.size() != 0) chk("head", {m_tuser, m_tlast, m_tdata}, q[0]);
    chk("stall_req", stall_req, m_stall);
    chk("overflow", overflow, m_ovf);
    if (m_tvalid && m_tready && rst_n) log_q.push_back({m_tuser, m_tlast, m_tdata});
  end
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  initial begin
    automatic int k;
    step();
    step();
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tdata", {m_tuser, m_tlast, m_tdata}, 0);
    chk("rst_stall", stall_req, 0);
    rst_n = 1;
    for (int i = 0; i < 12; i++) begin
      en = 1; vx_in = 12'(i); vy_in = 12'(i);
      step();
    end
    en = 0;
    repeat (3) step();
    chk("warm_count", log_q.size(), 9);
    chk("warm_first", {log_q[0][33:32], log_q[0][15:0]}, {2'b10, 16'd3});
    chk("warm_eol", {log_q[3][33:32], log_q[3][15:0]}, {2'b01, 16'd6});
    chk("warm_sof2", {log_q[8][33:32], log_q[8][15:0]}, {2'b10, 16'd11});
    m_tready = 0; en = 1; vx_in = 12'hFFE; vy_in = 12'h005;
    step();
    en = 0;
    chk("sign_pack", m_tdata, 32'h0005_FFFE);
    m_tready = 1;
    step();
    log_q.delete();
    m_tready = 0; en = 1; k = 0;
    while (!stall_req && k < 10) begin
      vx_in = 12'(100 + k);
      step();
      k++;
    end
    vx_in = 12'(100 + k);
    step();
    k++;
    en = 0;
    chk("bp_words", k, 3);
    chk("bp_ovf", overflow, 0);
    repeat (2) step();
    m_tready = 1;
    repeat (4) step();
    chk("bp_drain", log_q.size(), 3);
    for (int i = 0; i < 3 && i < log_q.size(); i++) chk("bp_order", log_q[i][15:0], 16'(100 + i));
    log_q.delete();
    m_tready = 0; en = 1;
    for (int i = 0; i < 6; i++) begin
      vx_in = 12'(200 + i);
      step();
    end
    en = 0;
    step();
    chk("ovf_set", overflow, 1);
    m_tready = 1;
    repeat (5) step();
    chk("ovf_sticky", overflow, 1);
    chk("ovf_kept", log_q.size(), 4);
    for (int i = 0; i < 4 && i < log_q.size(); i++) chk("ovf_order", log_q[i][15:0], 16'(200 + i));
    en = 1; vx_in = 12'd300;
    step();
    en = 0;
    step();
    chk("ovf_geom", log_q.size() == 5 ? {log_q[4][33:32], log_q[4][15:0]} : 18'h0, {2'b01, 16'd300});
    rst_n = 0;
    step();
    rst_n = 1;
    chk("rst2_ovf", overflow, 0);
    en = 1; vx_in = 0;
    repeat (3) step();
    log_q.delete();
    m_tready = 0;
    for (int i = 0; i < 4; i++) begin
      vx_in = 12'(500 + i);
      step();
    end
    chk("full_stall", stall_req, 1);
    m_tready = 1; vx_in = 12'd504;
    step();
    m_tready = 0; en = 0;
    step();
    chk("full_pop_ovf", overflow, 0);
    chk("full_pop_stall", stall_req, 1);
    m_tready = 1;
    repeat (6) step();
    chk("full_pop_words", log_q.size(), 5);
    if (log_q.size() == 5) begin
      chk("full_first", {log_q[0][33:32], log_q[0][15:0]}, {2'b10, 16'd500});
      chk("full_eol", {log_q[3][33:32], log_q[3][15:0]}, {2'b01, 16'd503});
      chk("full_last", {log_q[4][33:32], log_q[4][15:0]}, {2'b00, 16'd504});
    end
    m_tready = 0; en = 1;
    for (int i = 0; i < 3; i++) begin
      vx_in = 12'(600 + i);
      step();
    end
    en = 0;
    chk("mid_queued", m_tvalid, 1);
    rst_n = 0;
    step();
    rst_n = 1;
    chk("mid_tvalid", m_tvalid, 0);
    chk("mid_ovf", overflow, 0);
    chk("mid_outs", {m_tuser, m_tlast, m_tdata}, 0);
    log_q.delete();
    m_tready = 1; en = 1;
    for (int i = 0; i < 4; i++) begin
      vx_in = 12'(700 + i);
      step();
    end
    en = 0;
    repeat (2) step();
    chk("mid_count", log_q.size(), 1);
    if (log_q.size() != 0) chk("mid_first", {log_q[0][33], log_q[0][15:0]}, {1'b1, 16'd703});
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
